// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared ALU-decoder control codes and multiply/divide FSM encodings.
// Decoder, ALU and HI/LO unit all take their op codes from here.
package hilo_muldiv_unit_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] MULT_CONTROL  = 5'b10000;
    localparam logic [OP_W-1:0] MULTU_CONTROL = 5'b10001;
    localparam logic [OP_W-1:0] DIV_CONTROL   = 5'b10010;
    localparam logic [OP_W-1:0] DIVU_CONTROL  = 5'b10011;
    localparam logic [OP_W-1:0] MTHI_CONTROL  = 5'b10100;
    localparam logic [OP_W-1:0] MTLO_CONTROL  = 5'b10101;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == MULT_CONTROL) || (op == MULTU_CONTROL);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
    endfunction

    function automatic logic is_signed_op(input logic [OP_W-1:0] op);
        return (op == MULT_CONTROL) || (op == DIV_CONTROL);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and the mul/div unit.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);

    logic                                 start;
    logic [hilo_muldiv_unit_pkg::OP_W-1:0] op;
    logic [WIDTH-1:0]                     a;
    logic [WIDTH-1:0]                     b;
    logic                                 flush;
    logic                                 stall_o;
    logic                                 done_o;
    logic                                 div_zero_o;
    logic [WIDTH-1:0]                     hi_o;
    logic [WIDTH-1:0]                     lo_o;

    modport master (
        output start, op, a, b, flush,
        input  stall_o, done_o, div_zero_o, hi_o, lo_o
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall_o, done_o, div_zero_o, hi_o, lo_o
    );

endinterface

// File: rtl/hilo_muldiv_unit_datapath.sv
// Shift-add multiplier / restoring divider on one shared register pair, with sign fix-up.
// res_*_o carry the sign-corrected result of the step taken this cycle, for capture on the last step.
module muldiv_datapath #(
    parameter int WIDTH    = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             b_zero_o
);

    logic [WIDTH-1:0]   opb_q, acc_q, sh_q, acc_d, sh_d;
    logic               is_div_q, neg_q, neg_r_q;
    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, shifted, diff;
    logic [2*WIDTH-1:0] mul_next, prod;
    logic [WIDTH-1:0]   rem_n, quo_n;

    assign sa    = signed_i & a_i[WIDTH-1];
    assign sb    = signed_i & b_i[WIDTH-1];
    assign abs_a = sa ? -a_i : a_i;
    assign abs_b = sb ? -b_i : b_i;

    // opb holds the multiplicand or the divisor; sh holds the multiplier or the dividend/quotient.
    assign b_zero_o = (opb_q == '0);

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
        if (MUL_FAST) mul_next = {{WIDTH{1'b0}}, opb_q} * {{WIDTH{1'b0}}, sh_q};
        else          mul_next = {mul_sum, sh_q[WIDTH-1:1]};
        prod     = neg_q ? -mul_next : mul_next;
        shifted  = {acc_q, sh_q[WIDTH-1]};
        diff     = shifted - {1'b0, opb_q};
        rem_n    = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_n    = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
        if (is_div_q) begin
            acc_d    = rem_n;
            sh_d     = quo_n;
            res_hi_o = neg_r_q ? -rem_n : rem_n;
            res_lo_o = neg_q ? -quo_n : quo_n;
        end else begin
            {acc_d, sh_d}        = mul_next;
            {res_hi_o, res_lo_o} = prod;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            opb_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
        end else if (load_i) begin
            opb_q    <= div_i ? abs_b : abs_a;
            sh_q     <= div_i ? abs_a : abs_b;
            acc_q    <= '0;
            is_div_q <= div_i;
            neg_q    <= sa ^ sb;
            neg_r_q  <= sa;
        end else if (step_i) begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage HI/LO multiply/divide unit: FSM, iteration counter and the HI/LO registers.
// Stalls the pipeline from the accept cycle through the last iteration; done_o pulses in DONE.
module hilo_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    hilo_muldiv_unit_if.slave    md
);
    import hilo_muldiv_unit_pkg::*;

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MUL_LAST = MUL_FAST ? '0 : CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             load, step, stall, done;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             b_zero;

    muldiv_datapath #(.WIDTH(WIDTH), .MUL_FAST(MUL_FAST)) u_dp (
        .clk      (clk),
        .resetn   (resetn),
        .load_i   (load),
        .step_i   (step),
        .div_i    (is_div_op(md.op)),
        .signed_i (is_signed_op(md.op)),
        .a_i      (md.a),
        .b_i      (md.b),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo),
        .b_zero_o (b_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        load    = 1'b0;
        step    = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md.start && !md.flush) begin
                    if (is_mul_op(md.op) || is_div_op(md.op)) begin
                        load    = 1'b1;
                        stall   = 1'b1;
                        cnt_d   = '0;
                        state_d = is_div_op(md.op) ? MD_DIV : MD_MUL;
                    end else if (md.op == MTHI_CONTROL) begin
                        hi_d = md.a;
                    end else if (md.op == MTLO_CONTROL) begin
                        lo_d = md.a;
                    end
                end
            end
            MD_MUL, MD_DIV: begin
                stall = 1'b1;
                // A flush on the final iteration still wins: HI/LO are left untouched.
                if (md.flush) begin
                    state_d = MD_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ((state_q == MD_DIV) ? DIV_LAST : MUL_LAST)) begin
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                        dz_d    = (state_q == MD_DIV) && b_zero;
                        cnt_d   = '0;
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                done    = !md.flush;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign md.stall_o    = stall;
    assign md.done_o     = done;
    assign md.div_zero_o = done & dz_q;
    assign md.hi_o       = hi_q;
    assign md.lo_o       = lo_q;

endmodule
